// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings, "no branch"/"no jump"
// codes and the load-use match helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_REDIR = 2'd2,
        ST_MWAIT = 2'd3
    } hz_state_e;

    localparam logic [2:0] BR_NONE  = 3'b000;
    localparam logic [1:0] J_NONE   = 2'b00;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load into r0 never creates a dependency because r0 is hard-wired.
    function automatic logic load_use(
        input logic       ex_memread,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: advance only when not already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect flushes and memory-wait freeze.
// Controls are Mealy outputs of the registered FSM state and are forced low during reset.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int REDIR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_usesRt,
    input  logic [4:0]       Ex_Rt,
    input  logic             Ex_MemRead,
    input  logic [2:0]       Ex_Branch,
    input  logic [1:0]       Ex_jump,
    input  logic             Ex_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             IF_ID_hold,
    output logic             IF_ID_flush,
    output logic             ID_Ex_flush,
    output logic             ID_Ex_flush2,
    output logic             pipe_freeze,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam logic [1:0] REDIR_INIT = 2'(REDIR_CYCLES - 1);

    hz_state_e  state_d, state_q;
    logic [1:0] redir_cnt_d, redir_cnt_q;
    logic       lu_s, rd_s, mw_s;
    logic       pc_hold_s, if_id_hold_s, if_id_flush_s;
    logic       id_ex_flush_s, id_ex_flush2_s, pipe_freeze_s, redirect_s;
    logic       stall_inc_s, flush_inc_s;

    assign lu_s = load_use(Ex_MemRead, Ex_Rt, ID_Rs, ID_Rt, ID_usesRt);
    assign rd_s = (Ex_jump != J_NONE) || ((Ex_Branch != BR_NONE) && Ex_taken);
    assign mw_s = dmem_req && !dmem_ready;

    // Next state and controls; priority is memory wait, then redirect, then load-use.
    always_comb begin
        state_d        = state_q;
        redir_cnt_d    = redir_cnt_q;
        pc_hold_s      = 1'b0;
        if_id_hold_s   = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        id_ex_flush2_s = 1'b0;
        pipe_freeze_s  = 1'b0;
        redirect_s     = 1'b0;
        stall_inc_s    = 1'b0;
        flush_inc_s    = 1'b0;
        if (mw_s) begin
            pipe_freeze_s = 1'b1;
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            state_d       = ST_MWAIT;
        end else if (rd_s) begin
            redirect_s     = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_flush2_s = 1'b1;
            flush_inc_s    = 1'b1;
            redir_cnt_d    = REDIR_INIT;
            state_d        = ST_REDIR;
        end else if (lu_s && (state_q != ST_REDIR)) begin
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_flush_s = 1'b1;
            stall_inc_s   = 1'b1;
            state_d       = ST_LU;
        end else if (state_q == ST_REDIR) begin
            // Wrong-path instruction still in ID: keep squashing it.
            if_id_flush_s = 1'b1;
            if (redir_cnt_q == 2'd0) begin
                state_d = ST_RUN;
            end else begin
                redir_cnt_d = redir_cnt_q - 2'd1;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            redir_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc_s),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc_s),
        .cnt (flush_cnt)
    );

    assign pc_hold      = rst & pc_hold_s;
    assign IF_ID_hold   = rst & if_id_hold_s;
    assign IF_ID_flush  = rst & if_id_flush_s;
    assign ID_Ex_flush  = rst & id_ex_flush_s;
    assign ID_Ex_flush2 = rst & id_ex_flush2_s;
    assign pipe_freeze  = rst & pipe_freeze_s;
    assign redirect     = rst & redirect_s;
    assign state        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, saturation run,
// randomized traffic against a reference model, and an asynchronous reset mid-redirect.
module tb_hazard_ctrl;

    localparam int CW = 4;
    localparam int RC = 2;
    localparam int SAT = (1 << CW) - 1;

    // Expected control words {pc_hold, IF_ID_hold, IF_ID_flush, ID_Ex_flush, ID_Ex_flush2, pipe_freeze, redirect}
    localparam int C_0  = 32'b0000000;
    localparam int C_LU = 32'b1101000;
    localparam int C_RD = 32'b0010101;
    localparam int C_SH = 32'b0010000;
    localparam int C_MW = 32'b1100010;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          id_uses_rt, ex_memread, ex_taken, dmem_req, dmem_ready;
    logic [2:0]    ex_branch;
    logic [1:0]    ex_jump;
    logic          pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_flush2, pipe_freeze, redirect;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state;
    logic [6:0]    ctl_act;

    int n_vec = 0;
    int n_bad = 0;

    hazard_ctrl #(.CNT_W(CW), .REDIR_CYCLES(RC)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_usesRt(id_uses_rt),
        .Ex_Rt(ex_rt), .Ex_MemRead(ex_memread), .Ex_Branch(ex_branch),
        .Ex_jump(ex_jump), .Ex_taken(ex_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_hold(pc_hold), .IF_ID_hold(if_id_hold), .IF_ID_flush(if_id_flush),
        .ID_Ex_flush(id_ex_flush), .ID_Ex_flush2(id_ex_flush2),
        .pipe_freeze(pipe_freeze), .redirect(redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    always #5 clk = ~clk;

    assign ctl_act = {pc_hold, if_id_hold, if_id_flush, id_ex_flush, id_ex_flush2, pipe_freeze, redirect};

    typedef struct {
        int rs, rt, ur, er, mr, br, j, tk, rq, rdy;
        int ctl, st, sc, fc;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input int rs, rt, ur, er, mr, br, j, tk, rq, rdy, ctl, st, sc, fc);
        vec_t v;
        v = '{rs, rt, ur, er, mr, br, j, tk, rq, rdy, ctl, st, sc, fc};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int rs, rt, ur, er, mr, br, j, tk, rq, rdy);
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_uses_rt = 1'(ur);
        ex_rt      = 5'(er);
        ex_memread = 1'(mr);
        ex_branch  = 3'(br);
        ex_jump    = 2'(j);
        ex_taken   = 1'(tk);
        dmem_req   = 1'(rq);
        dmem_ready = 1'(rdy);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(5, 5, 1, 5, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        chk("rst_ctl", 32'(ctl_act), C_0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    function automatic int sat_inc(input int x);
        return (x >= SAT) ? SAT : x + 1;
    endfunction

    int m_left, m_state, m_stall, m_flush;
    int r_rs, r_rt, r_ur, r_er, r_mr, r_br, r_j, r_tk, r_rq, r_rdy;
    int e_ctl;
    bit b_mw, b_rd, b_lu, b_shadow;

    initial begin
        //            rs rt ur er mr br j tk rq rdy   ctl   st sc fc
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  0, 0, 0);
        tbl[1]  = mk(5, 0, 0, 5, 1, 0, 0, 0, 0, 0,  C_LU, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  C_0,  0, 1, 0);
        tbl[4]  = mk(1, 3, 1, 3, 1, 0, 0, 0, 0, 0,  C_LU, 0, 1, 0);
        tbl[5]  = mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 0,  C_0,  1, 2, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0,  C_RD, 0, 2, 0);
        tbl[7]  = mk(7, 0, 0, 7, 1, 0, 0, 0, 0, 0,  C_SH, 2, 2, 1);
        tbl[8]  = mk(7, 0, 0, 7, 1, 0, 0, 0, 0, 0,  C_SH, 2, 2, 1);
        tbl[9]  = mk(7, 0, 0, 7, 1, 0, 0, 0, 0, 0,  C_LU, 0, 2, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  1, 3, 1);
        tbl[11] = mk(7, 0, 0, 7, 1, 0, 1, 0, 0, 0,  C_RD, 0, 3, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_SH, 2, 3, 2);
        tbl[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  C_SH, 2, 3, 2);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  0, 3, 2);
        tbl[15] = mk(5, 0, 0, 5, 1, 0, 0, 0, 1, 0,  C_MW, 0, 3, 2);
        tbl[16] = mk(5, 0, 0, 5, 1, 0, 0, 0, 1, 0,  C_MW, 3, 3, 2);
        tbl[17] = mk(5, 0, 0, 5, 1, 0, 0, 0, 1, 0,  C_MW, 3, 3, 2);
        tbl[18] = mk(5, 0, 0, 5, 1, 0, 0, 0, 1, 1,  C_LU, 3, 3, 2);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  1, 4, 2);
        tbl[20] = mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0,  C_RD, 0, 4, 2);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_SH, 2, 4, 3);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 2, 0, 0, 0,  C_RD, 2, 4, 3);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_SH, 2, 4, 4);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_SH, 2, 4, 4);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  C_0,  0, 4, 4);

        do_reset();

        for (int i = 0; i < 26; i++) begin
            @(posedge clk);
            #1 drive(tbl[i].rs, tbl[i].rt, tbl[i].ur, tbl[i].er, tbl[i].mr,
                     tbl[i].br, tbl[i].j, tbl[i].tk, tbl[i].rq, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d_ctl", i), 32'(ctl_act), 32'(tbl[i].ctl));
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].sc));
            chk($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(tbl[i].fc));
        end

        // Twenty load-use events: stall_cnt climbs from 4 and sticks at all-ones.
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 drive(5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("sat%0d_stall", k), 32'(stall_cnt), 32'((5 + k > SAT) ? SAT : 5 + k));
        end

        // Randomized traffic against the reference model.
        do_reset();
        m_left = 0; m_state = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 1500; c++) begin
            r_rs  = $urandom_range(0, 3);
            r_rt  = $urandom_range(0, 3);
            r_ur  = $urandom_range(0, 1);
            r_er  = $urandom_range(0, 3);
            r_mr  = $urandom_range(0, 1);
            r_br  = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 7);
            r_j   = ($urandom_range(0, 9) < 9) ? 0 : $urandom_range(1, 3);
            r_tk  = $urandom_range(0, 1);
            r_rq  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r_rdy = $urandom_range(0, 1);
            @(posedge clk);
            #1 drive(r_rs, r_rt, r_ur, r_er, r_mr, r_br, r_j, r_tk, r_rq, r_rdy);

            b_mw     = (r_rq != 0) && (r_rdy == 0);
            b_rd     = (r_j != 0) || ((r_br != 0) && (r_tk != 0));
            b_lu     = (r_mr != 0) && (r_er != 0) && ((r_er == r_rs) || ((r_ur != 0) && (r_er == r_rt)));
            b_shadow = (m_left > 0);
            if (b_mw)                  e_ctl = C_MW;
            else if (b_rd)             e_ctl = C_RD;
            else if (b_lu && !b_shadow) e_ctl = C_LU;
            else if (b_shadow)         e_ctl = C_SH;
            else                       e_ctl = C_0;

            @(negedge clk);
            chk($sformatf("rnd%0d_ctl", c), 32'(ctl_act), 32'(e_ctl));
            chk($sformatf("rnd%0d_state", c), 32'(state), 32'(m_state));
            chk($sformatf("rnd%0d_stall", c), 32'(stall_cnt), 32'(m_stall));
            chk($sformatf("rnd%0d_flush", c), 32'(flush_cnt), 32'(m_flush));

            if (b_mw) begin
                m_left = 0;
                m_state = 3;
            end else if (b_rd) begin
                m_flush = sat_inc(m_flush);
                m_left = RC;
                m_state = 2;
            end else if (b_lu && !b_shadow) begin
                m_stall = sat_inc(m_stall);
                m_state = 1;
            end else if (b_shadow) begin
                m_left = m_left - 1;
                m_state = (m_left > 0) ? 2 : 0;
            end else begin
                m_state = 0;
            end
        end

        // Asynchronous reset in the middle of a redirect sequence.
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_state", 32'(state), 32'd2);
        #2 drive(5, 0, 0, 5, 1, 0, 1, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("arst_ctl", 32'(ctl_act), C_0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_flush", 32'(flush_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
